picomips_core: RTL

Parametrised successor to the team's picoMIPS affine processor core. It executes a fixed-format instruction stream from a synchronous program memory (1-cycle read latency) and moves data through two independent valid/ready handshake ports. It is generalised in data width, register count, PC width and fixed-point format, and adds non-zero branch, halt, and optional saturation on the affine multiply. It sits between `prog_mem` and the board I/O, with `addr` also feeding the LED decoders.

---
 rtl/picomips_core.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/picomips_core.sv
// rtl/picomips_core.sv - parametrised picoMIPS affine processor core
module picomips_core #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int PC_W   = 5,
  parameter int FRAC   = 7,
  parameter bit SAT    = 1'b1,
  localparam int RA = $clog2(NREG),
  localparam int IW = DATA_W + 3*RA + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     inp,
  output logic [PC_W-1:0]   addr,
  input  logic [DATA_W-1:0] datin,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] datout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              waiting,
  output logic              halted
);

  localparam logic [3:0] OP_LD   = 4'd0;
  localparam logic [3:0] OP_LI   = 4'd1;
  localparam logic [3:0] OP_ST   = 4'd2;
  localparam logic [3:0] OP_BEQZ = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AFF  = 4'd5;
  localparam logic [3:0] OP_BNEZ = 4'd6;
  localparam logic [3:0] OP_ADD  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;
  localparam int PW = 2*DATA_W;

  typedef enum logic [2:0] {S_FILL, S_RUN, S_BUBBLE, S_WAIT_RD, S_WAIT_WR, S_HALT} state_t;

  state_t state, state_n;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [RA-1:0]     ld_rd;
  logic [3:0]        op;
  logic [RA-1:0]     rd, rs1, rs2;
  logic [DATA_W-1:0] imm, rs1_val, rs2_val, aff_res;
  logic signed [PW-1:0] prod, shq;

  logic [PC_W-1:0]   addr_n;
  logic              reg_we, ld_issue, st_issue, ld_done, st_done;
  logic [RA-1:0]     reg_wa;
  logic [DATA_W-1:0] reg_wd;

  assign op  = inp[3:0];
  assign rs2 = inp[4 +: RA];
  assign rs1 = inp[4+RA +: RA];
  assign rd  = inp[4+2*RA +: RA];
  assign imm = inp[4+3*RA +: DATA_W];

  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];

  assign prod = $signed(rs1_val) * $signed(rs2_val);
  assign shq  = prod >>> FRAC;

  assign waiting = (state == S_FILL) || (state == S_BUBBLE) ||
                   (state == S_WAIT_RD) || (state == S_WAIT_WR);
  assign halted  = (state == S_HALT);

  // affine result: clamp when the shifted product does not fit in DATA_W signed bits
  always_comb begin
    aff_res = shq[DATA_W-1:0];
    if (SAT && (shq[PW-1:DATA_W-1] != {(DATA_W+1){shq[PW-1]}}))
      aff_res = shq[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FILL;
    else     state <= state_n;
  end

  // next state, next fetch address, register write and handshake strobes
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    reg_we   = 1'b0;
    reg_wa   = rd;
    reg_wd   = imm;
    ld_issue = 1'b0;
    st_issue = 1'b0;
    ld_done  = 1'b0;
    st_done  = 1'b0;
    case (state)
      S_FILL, S_BUBBLE: begin
        addr_n  = addr + PC_W'(1);
        state_n = S_RUN;
      end
      S_RUN: begin
        addr_n = addr + PC_W'(1);
        case (op)
          OP_LD:   begin addr_n = addr; ld_issue = 1'b1; state_n = S_WAIT_RD; end
          OP_LI:   reg_we = 1'b1;
          OP_ST:   begin addr_n = addr; st_issue = 1'b1; state_n = S_WAIT_WR; end
          OP_BEQZ: if (rs1_val == '0) begin addr_n = imm[PC_W-1:0]; state_n = S_BUBBLE; end
          OP_SUB:  begin reg_we = 1'b1; reg_wd = rs1_val - rs2_val; end
          OP_AFF:  begin reg_we = 1'b1; reg_wd = aff_res; end
          OP_BNEZ: if (rs1_val != '0) begin addr_n = imm[PC_W-1:0]; state_n = S_BUBBLE; end
          OP_ADD:  begin reg_we = 1'b1; reg_wd = rs1_val + rs2_val; end
          OP_HALT: begin addr_n = addr; state_n = S_HALT; end
          default: ;
        endcase
      end
      S_WAIT_RD: begin
        if (in_valid && in_ready) begin
          reg_we  = 1'b1;
          reg_wa  = ld_rd;
          reg_wd  = datin;
          ld_done = 1'b1;
          addr_n  = addr + PC_W'(1);
          state_n = S_RUN;
        end
      end
      S_WAIT_WR: begin
        if (out_valid && out_ready) begin
          st_done = 1'b1;
          addr_n  = addr + PC_W'(1);
          state_n = S_RUN;
        end
      end
      default: ;
    endcase
  end

  // datapath: fetch address, register file and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      regs      <= '0;
      ld_rd     <= '0;
      datout    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      addr <= addr_n;
      if (reg_we) regs[reg_wa] <= reg_wd;
      if (ld_issue) begin
        in_ready <= 1'b1;
        ld_rd    <= rd;
      end else if (ld_done) begin
        in_ready <= 1'b0;
      end
      if (st_issue) begin
        out_valid <= 1'b1;
        datout    <= rs1_val;
      end else if (st_done) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
